// File: rtl/eyeriss_pkg.sv
// Shared definitions for the Eyeriss conv3 core: bank indices, controller states
// and the GLB address layout helpers used by the controller.
package eyeriss_pkg;

    localparam int IFMAP_BANK = 0;
    localparam int PSUM_BANK  = 1;
    localparam int WGHT_BANK  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_INIT,
        ST_MAC,
        ST_WR,
        ST_DONE
    } state_e;

    // Padded input plane of side h, channel-major.
    function automatic logic [31:0] ifmap_addr(input logic [15:0] c, y, x, h);
        return (32'(c) * 32'(h) + 32'(y)) * 32'(h) + 32'(x);
    endfunction

    function automatic logic [31:0] wght_addr(input logic [15:0] m, c, r, s, nc, rs);
        return ((32'(m) * 32'(nc) + 32'(c)) * 32'(rs) + 32'(r)) * 32'(rs) + 32'(s);
    endfunction

    function automatic logic [31:0] psum_addr(input logic [15:0] m, oy, ox, e);
        return (32'(m) * 32'(e) + 32'(oy)) * 32'(e) + 32'(ox);
    endfunction

    // Outputs live directly after the M*E*E init words.
    function automatic logic [31:0] out_addr(input logic [15:0] m, oy, ox, e, nm);
        return 32'(nm) * 32'(e) * 32'(e) + psum_addr(m, oy, ox, e);
    endfunction

endpackage

// File: rtl/glb_bank.sv
// Single-port GLB bank: one read or one write per cycle, registered read data.
module glb_bank #(
    parameter int DEPTH = 8192,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] BRAM [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (we) begin
            BRAM[addr] <= wdata;
        end else begin
            rdata <= BRAM[addr];
        end
    end

endmodule

// File: rtl/eyeriss_conv_wrapper.sv
// Conv3 accelerator core: three-bank GLB plus a sequential controller that
// walks every output pixel, accumulating init + sum(ifmap * weight) into the psum bank.
module eyeriss_conv_wrapper
    import eyeriss_pkg::*;
#(
    parameter int BANK_NUM              = 3,
    parameter int BANK_DEPTH            = 8192,
    parameter int DATA_BITWIDTH         = 32,
    parameter int NUM_ROWS              = 3,
    parameter int NUM_COLS              = 13,
    parameter int IN_CH                 = 4,
    parameter int OUT_CH                = 16,
    parameter int IFMAP_ROW_ID_BITWIDTH = 4,
    parameter int WGHT_ROW_ID_BITWIDTH  = 4,
    parameter int PSUM_ROW_ID_BITWIDTH  = 4,
    parameter int IFMAP_COL_ID_BITWIDTH = 5,
    parameter int WGHT_COL_ID_BITWIDTH  = 4,
    parameter int PSUM_COL_ID_BITWIDTH  = 4,
    parameter int IFMAP_BUS_BITWIDTH    = 32,
    parameter int WGHT_BUS_BITWIDTH     = 32,
    parameter int PSUM_BUS_BITWIDTH     = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_core_start,
    output logic o_core_done
);

    localparam int          AW      = $clog2(BANK_DEPTH);
    localparam logic [15:0] DIM_C   = 16'(IN_CH);
    localparam logic [15:0] DIM_M   = 16'(OUT_CH);
    localparam logic [15:0] DIM_R   = 16'(NUM_ROWS);
    localparam logic [15:0] DIM_E   = 16'(NUM_COLS);
    localparam logic [15:0] DIM_H   = 16'(NUM_COLS + NUM_ROWS - 1);
    localparam logic [15:0] C_LAST  = 16'(IN_CH - 1);
    localparam logic [15:0] M_LAST  = 16'(OUT_CH - 1);
    localparam logic [15:0] RS_LAST = 16'(NUM_ROWS - 1);
    localparam logic [15:0] E_LAST  = 16'(NUM_COLS - 1);

    if (BANK_NUM != WGHT_BANK + 1 ||
        IFMAP_BUS_BITWIDTH != DATA_BITWIDTH || WGHT_BUS_BITWIDTH != DATA_BITWIDTH ||
        PSUM_BUS_BITWIDTH != DATA_BITWIDTH ||
        IFMAP_ROW_ID_BITWIDTH < 1 || WGHT_ROW_ID_BITWIDTH < 1 || PSUM_ROW_ID_BITWIDTH < 1 ||
        IFMAP_COL_ID_BITWIDTH < 1 || WGHT_COL_ID_BITWIDTH < 1 || PSUM_COL_ID_BITWIDTH < 1) begin : g_bad_cfg
        $error("eyeriss_conv_wrapper: unsupported bank count or bus width configuration");
    end

    // Wrap-around multiply-accumulate: product and sum both truncated to the word width.
    function automatic logic signed [DATA_BITWIDTH-1:0] mac_wrap(
        input logic signed [DATA_BITWIDTH-1:0] acc,
        input logic signed [DATA_BITWIDTH-1:0] a,
        input logic signed [DATA_BITWIDTH-1:0] b
    );
        return acc + a * b;
    endfunction

    state_e                            state_q, state_d;
    logic [15:0]                       m_q, oy_q, ox_q, c_q, r_q, s_q;
    logic                              issue_done_q;
    logic                              init_p1, vld_p1;
    logic signed [DATA_BITWIDTH-1:0]   acc_q;

    logic                              mac_rd;
    logic                              last_step, last_out;
    logic [AW-1:0]                     if_addr, wt_addr, ps_addr;
    logic                              ps_we;
    logic [PSUM_BUS_BITWIDTH-1:0]      ps_wdata;
    logic [IFMAP_BUS_BITWIDTH-1:0]     if_rdata;
    logic [WGHT_BUS_BITWIDTH-1:0]      wt_rdata;
    logic [PSUM_BUS_BITWIDTH-1:0]      ps_rdata;

    if (1) begin : glb_inst
        glb_bank #(.DEPTH(BANK_DEPTH), .WIDTH(DATA_BITWIDTH)) u_glb_bank_ifmap (
            .i_clk (i_clk),
            .we    (1'b0),
            .addr  (if_addr),
            .wdata ('0),
            .rdata (if_rdata)
        );
        glb_bank #(.DEPTH(BANK_DEPTH), .WIDTH(DATA_BITWIDTH)) u_glb_bank_psum (
            .i_clk (i_clk),
            .we    (ps_we),
            .addr  (ps_addr),
            .wdata (ps_wdata),
            .rdata (ps_rdata)
        );
        glb_bank #(.DEPTH(BANK_DEPTH), .WIDTH(DATA_BITWIDTH)) u_glb_bank_wght (
            .i_clk (i_clk),
            .we    (1'b0),
            .addr  (wt_addr),
            .wdata ('0),
            .rdata (wt_rdata)
        );
    end

    assign last_step   = (s_q == RS_LAST) && (r_q == RS_LAST) && (c_q == C_LAST);
    assign last_out    = (ox_q == E_LAST) && (oy_q == E_LAST) && (m_q == M_LAST);
    assign o_core_done = (state_q == ST_DONE);

    always_comb begin
        state_d  = state_q;
        mac_rd   = 1'b0;
        ps_we    = 1'b0;
        ps_addr  = '0;
        ps_wdata = '0;
        if_addr  = '0;
        wt_addr  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_core_start) state_d = ST_RD_INIT;
            end
            ST_RD_INIT: begin
                ps_addr = AW'(psum_addr(m_q, oy_q, ox_q, DIM_E));
                state_d = ST_MAC;
            end
            ST_MAC: begin
                // Reads stop after the last tap; one more cycle drains its product.
                if (!issue_done_q) begin
                    mac_rd  = 1'b1;
                    if_addr = AW'(ifmap_addr(c_q, oy_q + r_q, ox_q + s_q, DIM_H));
                    wt_addr = AW'(wght_addr(m_q, c_q, r_q, s_q, DIM_C, DIM_R));
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                ps_we    = 1'b1;
                ps_addr  = AW'(out_addr(m_q, oy_q, ox_q, DIM_E, DIM_M));
                ps_wdata = acc_q;
                state_d  = last_out ? ST_DONE : ST_RD_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            m_q          <= '0;
            oy_q         <= '0;
            ox_q         <= '0;
            c_q          <= '0;
            r_q          <= '0;
            s_q          <= '0;
            issue_done_q <= 1'b0;
            init_p1      <= 1'b0;
            vld_p1       <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q <= state_d;
            init_p1 <= (state_q == ST_RD_INIT);
            vld_p1  <= mac_rd;

            // Bank data arrives one cycle after the address was issued.
            if (state_q == ST_MAC) begin
                if (init_p1) begin
                    acc_q <= signed'(ps_rdata);
                end else if (vld_p1) begin
                    acc_q <= mac_wrap(acc_q, signed'(if_rdata), signed'(wt_rdata));
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_core_start) begin
                        m_q  <= '0;
                        oy_q <= '0;
                        ox_q <= '0;
                    end
                end
                ST_RD_INIT: begin
                    c_q          <= '0;
                    r_q          <= '0;
                    s_q          <= '0;
                    issue_done_q <= 1'b0;
                end
                ST_MAC: begin
                    if (mac_rd) begin
                        if (last_step) issue_done_q <= 1'b1;
                        if (s_q == RS_LAST) begin
                            s_q <= '0;
                            if (r_q == RS_LAST) begin
                                r_q <= '0;
                                c_q <= c_q + 16'd1;
                            end else begin
                                r_q <= r_q + 16'd1;
                            end
                        end else begin
                            s_q <= s_q + 16'd1;
                        end
                    end
                end
                ST_WR: begin
                    if (ox_q == E_LAST) begin
                        ox_q <= '0;
                        if (oy_q == E_LAST) begin
                            oy_q <= '0;
                            m_q  <= m_q + 16'd1;
                        end else begin
                            oy_q <= oy_q + 16'd1;
                        end
                    end else begin
                        ox_q <= ox_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eyeriss_conv_wrapper.sv
// Self-checking bench for eyeriss_conv_wrapper on a reduced layer (C=2, M=3, E=4, R=3).
module tb_eyeriss_conv_wrapper;

    localparam int DEPTH  = 128;
    localparam int R      = 3;
    localparam int E      = 4;
    localparam int C      = 2;
    localparam int M      = 3;
    localparam int H      = E + R - 1;
    localparam int NOUT   = M * E * E;
    localparam int CRS    = C * R * R;
    localparam int BUDGET = 5000;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic done;

    always #5 clk = ~clk;

    eyeriss_conv_wrapper #(
        .BANK_DEPTH (DEPTH),
        .NUM_ROWS   (R),
        .NUM_COLS   (E),
        .IN_CH      (C),
        .OUT_CH     (M)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_core_start (start),
        .o_core_done  (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] ifm     [0:DEPTH-1];
    logic [31:0] wgt     [0:DEPTH-1];
    logic [31:0] ini     [0:DEPTH-1];
    logic [31:0] exp_mem [0:DEPTH-1];

    bit mon_en     = 1'b0;
    bit run_active = 1'b0;
    bit exp_done   = 1'b0;
    bit done_prev  = 1'b0;
    int wr_cnt     = 0;
    int done_rises = 0;
    int wa;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: straight nested-loop convolution with 32-bit wrap.
    task automatic compute_expected();
        logic [31:0] acc;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hDEADBEEF;
        for (int i = 0; i < NOUT; i++) exp_mem[i] = ini[i];
        for (int m = 0; m < M; m++)
            for (int oy = 0; oy < E; oy++)
                for (int ox = 0; ox < E; ox++) begin
                    acc = ini[m*E*E + oy*E + ox];
                    for (int c = 0; c < C; c++)
                        for (int r = 0; r < R; r++)
                            for (int s = 0; s < R; s++)
                                acc = acc + ifm[c*H*H + (oy+r)*H + (ox+s)] * wgt[((m*C + c)*R + r)*R + s];
                    exp_mem[NOUT + m*E*E + oy*E + ox] = acc;
                end
    endtask

    // kind: 0 ones, 1 zero weights with ramp init, 2 ramp ifmap with one weight,
    // 3 overflow, 4 random
    task automatic fill(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            ifm[i] = 32'd0;
            wgt[i] = 32'd0;
            ini[i] = 32'd0;
        end
        for (int i = 0; i < C*H*H; i++) begin
            case (kind)
                0:       ifm[i] = 32'd1;
                1:       ifm[i] = $urandom;
                2:       ifm[i] = 32'(i);
                3:       ifm[i] = 32'h8000_0000;
                default: ifm[i] = $urandom;
            endcase
        end
        for (int i = 0; i < M*C*R*R; i++) begin
            case (kind)
                0:       wgt[i] = 32'd1;
                1:       wgt[i] = 32'd0;
                2:       wgt[i] = (i == 0) ? 32'd2 : 32'd0;
                3:       wgt[i] = 32'd2;
                default: wgt[i] = $urandom;
            endcase
        end
        for (int i = 0; i < NOUT; i++) begin
            case (kind)
                1:       ini[i] = 32'(i);
                3:       ini[i] = 32'd5;
                4:       ini[i] = $urandom;
                default: ini[i] = 32'd0;
            endcase
        end
    endtask

    task automatic load();
        for (int i = 0; i < DEPTH; i++) begin
            dut.glb_inst.u_glb_bank_ifmap.BRAM[i] = ifm[i];
            dut.glb_inst.u_glb_bank_wght.BRAM[i]  = wgt[i];
            dut.glb_inst.u_glb_bank_psum.BRAM[i]  = (i < NOUT) ? ini[i] : 32'hDEADBEEF;
        end
        compute_expected();
    endtask

    task automatic run_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wr_cnt     = 0;
        exp_done   = 1'b0;
        run_active = 1'b1;
        done_rises = 0;
    endtask

    task automatic pulse_ignored();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_in_budget"}, {31'b0, done}, 32'd1);
        repeat (20) @(negedge clk);
        run_active = 1'b0;
        check({tag, "_write_count"}, 32'(wr_cnt), 32'(NOUT));
        check({tag, "_done_rises"}, 32'(done_rises), 32'd1);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 2*NOUT; i++)
            check({tag, "_mem"}, dut.glb_inst.u_glb_bank_psum.BRAM[i], exp_mem[i]);
    endtask

    // Per-cycle compare: done level and every psum-bank write against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done_level", {31'b0, done}, {31'b0, exp_done});
            if (done && !done_prev) done_rises++;
            done_prev = done;
            if (dut.glb_inst.u_glb_bank_psum.we !== 1'b0) begin
                wa = int'(dut.glb_inst.u_glb_bank_psum.addr);
                check("write_legal", {31'b0, run_active && wa >= NOUT && wa < 2*NOUT}, 32'd1);
                if (wa >= NOUT && wa < 2*NOUT)
                    check("write_data", dut.glb_inst.u_glb_bank_psum.wdata, exp_mem[wa]);
                wr_cnt++;
                if (wr_cnt == NOUT) exp_done = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_done", {31'b0, done}, 32'd0);
        mon_en = 1'b1;
        repeat (1000) @(posedge clk);

        fill(0); load();
        check("model_ones", exp_mem[NOUT], 32'(CRS));
        run_start(); wait_done("ones"); sweep("ones");
        check("ones_first_out", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT], 32'd18);

        fill(1); load();
        run_start(); wait_done("wzero"); sweep("wzero");
        check("wzero_last_out", dut.glb_inst.u_glb_bank_psum.BRAM[2*NOUT-1], 32'(NOUT-1));

        fill(2); load();
        check("model_ramp", exp_mem[NOUT + 5], 32'd14);
        run_start(); wait_done("ramp"); sweep("ramp");
        check("ramp_m0_11", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT + 1*E + 1], 32'd14);
        check("ramp_m0_33", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT + 3*E + 3], 32'd42);
        check("ramp_m1_00", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT + E*E], 32'd0);

        fill(3); load();
        run_start(); wait_done("ovf"); sweep("ovf");
        check("ovf_out", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT + 7], 32'd5);

        for (int t = 0; t < 2; t++) begin
            fill(4); load();
            run_start(); wait_done("rand"); sweep("rand");
        end

        fill(4); load();
        run_start();
        repeat (100) @(posedge clk);
        pulse_ignored();
        wait_done("xstart"); sweep("xstart");

        fill(0); load();
        run_start();
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 run_active = 1'b0;
        exp_done = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_partial", {31'b0, (wr_cnt > 0) && (wr_cnt < NOUT)}, 32'd1);
        load();
        run_start(); wait_done("midrst"); sweep("midrst");
        check("midrst_first_out", dut.glb_inst.u_glb_bank_psum.BRAM[NOUT], 32'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
